lsu_req_ctrl: RTL and testbench

LSU_REQ_CTRL -- requirements
Module: lsu_req_ctrl

---
 rtl/lsu_req_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_lsu_req_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_req_ctrl.sv
// Load/store request controller: drives an sram-like request channel from the EX stage and
// tracks outstanding requests so returning data can be aligned and delivered to MEM.
module lsu_req_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_OUTS = 2
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                req_valid_i,
    input  logic                req_we_i,
    input  logic [1:0]          req_size_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic                flush_i,
    output logic                req_ready_o,
    output logic                ale_o,

    output logic                data_req_o,
    output logic                data_wr_o,
    output logic [1:0]          data_size_o,
    output logic [DATA_W/8-1:0] data_wstrb_o,
    output logic [ADDR_W-1:0]   data_addr_o,
    output logic [DATA_W-1:0]   data_wdata_o,
    input  logic                data_addr_ok_i,
    input  logic                data_data_ok_i,
    input  logic [DATA_W-1:0]   data_rdata_i,

    output logic                resp_valid_o,
    output logic                resp_we_o,
    output logic [DATA_W-1:0]   resp_rdata_o,
    output logic [2:0]          outs_cnt_o
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF   = $clog2(NB);
    localparam int unsigned PTR_W = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam logic [2:0]  MAX_CNT  = 3'(MAX_OUTS);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTS - 1);

    typedef enum logic [0:0] {StIdle, StWaitAddr} state_e;

    typedef struct packed {
        logic           we;
        logic [OFF-1:0] off;
    } meta_t;

    state_e state_q, state_d;

    logic                misaligned;
    logic [NB-1:0]       req_strb;
    logic [DATA_W-1:0]   req_wdata_rep;

    logic                lat_we_q;
    logic [1:0]          lat_size_q;
    logic [ADDR_W-1:0]   lat_addr_q;
    logic [NB-1:0]       lat_strb_q;
    logic [DATA_W-1:0]   lat_wdata_q;
    logic                flush_seen_q;
    logic                lat_load;

    logic                data_req;
    logic                ready;
    logic                push;
    logic                push_stale;
    logic                pop;
    meta_t               push_meta;
    meta_t               head;
    logic                head_stale;

    meta_t               meta_q [MAX_OUTS];
    logic [MAX_OUTS-1:0] stale_q, stale_d;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [2:0]          cnt_q, cnt_d;

    logic                resp_valid_q;
    logic                resp_we_q;
    logic [DATA_W-1:0]   resp_rdata_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Size 3 can never be aligned on a 32-bit bus.
    always_comb begin
        misaligned = 1'b0;
        case (req_size_i)
            2'd1:    misaligned = req_addr_i[0];
            2'd2:    misaligned = |req_addr_i[1:0];
            2'd3:    misaligned = (DATA_W == 32) ? 1'b1 : |req_addr_i[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign ale_o = req_valid_i & misaligned;

    always_comb begin
        int nbytes;
        int off;
        nbytes        = 1 << req_size_i;
        off           = int'(req_addr_i[OFF-1:0]);
        req_strb      = '0;
        req_wdata_rep = '0;
        for (int b = 0; b < int'(NB); b++) begin
            if (req_we_i && (b >= off) && (b < off + nbytes)) begin
                req_strb[b] = 1'b1;
            end
            req_wdata_rep[8*b +: 8] = req_wdata_i[8*(b & (nbytes - 1)) +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        data_req     = 1'b0;
        ready        = 1'b0;
        push         = 1'b0;
        push_stale   = 1'b0;
        lat_load     = 1'b0;
        data_wr_o    = req_we_i;
        data_size_o  = req_size_i;
        data_addr_o  = req_addr_i;
        data_wstrb_o = req_strb;
        data_wdata_o = req_wdata_rep;
        unique case (state_q)
            StIdle: begin
                data_req = req_valid_i & ~ale_o & ~flush_i & (cnt_q < MAX_CNT);
                if (data_req) begin
                    if (data_addr_ok_i) begin
                        ready = 1'b1;
                        push  = 1'b1;
                    end else begin
                        lat_load = 1'b1;
                        state_d  = StWaitAddr;
                    end
                end
            end
            StWaitAddr: begin
                // Held request is committed to the bus; a flush can only mark it stale.
                data_req     = 1'b1;
                data_wr_o    = lat_we_q;
                data_size_o  = lat_size_q;
                data_addr_o  = lat_addr_q;
                data_wstrb_o = lat_strb_q;
                data_wdata_o = lat_wdata_q;
                if (data_addr_ok_i) begin
                    push       = 1'b1;
                    push_stale = flush_seen_q | flush_i;
                    ready      = ~push_stale;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_req_o  = data_req & rst_n;
    assign req_ready_o = ready & rst_n;

    assign push_meta  = '{we: data_wr_o, off: data_addr_o[OFF-1:0]};
    assign pop        = data_data_ok_i & (cnt_q != 3'd0);
    assign head       = meta_q[rd_ptr_q];
    assign head_stale = stale_q[rd_ptr_q] | flush_i;

    always_comb begin
        stale_d = stale_q;
        if (push) begin
            stale_d[wr_ptr_q] = push_stale;
        end
        if (flush_i) begin
            stale_d = '1;
        end
    end

    always_comb begin
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            lat_we_q     <= 1'b0;
            lat_size_q   <= '0;
            lat_addr_q   <= '0;
            lat_strb_q   <= '0;
            lat_wdata_q  <= '0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (lat_load) begin
                lat_we_q     <= req_we_i;
                lat_size_q   <= req_size_i;
                lat_addr_q   <= req_addr_i;
                lat_strb_q   <= req_strb;
                lat_wdata_q  <= req_wdata_rep;
                flush_seen_q <= 1'b0;
            end else if (state_q == StWaitAddr && flush_i) begin
                flush_seen_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_OUTS); i++) begin
                meta_q[i] <= '0;
            end
            stale_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                meta_q[wr_ptr_q] <= push_meta;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            stale_q <= stale_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= pop & ~head_stale;
            if (pop) begin
                resp_we_q    <= head.we;
                resp_rdata_q <= data_rdata_i >> {head.off, 3'b000};
            end
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_we_o    = resp_we_q;
    assign resp_rdata_o = resp_rdata_q;
    assign outs_cnt_o   = cnt_q;

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Bench for lsu_req_ctrl: directed scenarios plus random traffic, all checked against a
// transaction-level model (queue of outstanding requests plus one held request).
module tb_lsu_req_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_i, req_we_i, flush_i;
    logic [1:0]    req_size_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic          req_ready_o, ale_o;
    logic          data_req_o, data_wr_o;
    logic [1:0]    data_size_o;
    logic [3:0]    data_wstrb_o;
    logic [AW-1:0] data_addr_o;
    logic [DW-1:0] data_wdata_o;
    logic          data_addr_ok_i, data_data_ok_i;
    logic [DW-1:0] data_rdata_i;
    logic          resp_valid_o, resp_we_o;
    logic [DW-1:0] resp_rdata_o;
    logic [2:0]    outs_cnt_o;

    lsu_req_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MAX_OUTS(MO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .flush_i        (flush_i),
        .req_ready_o    (req_ready_o),
        .ale_o          (ale_o),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_wstrb_o   (data_wstrb_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_we_o      (resp_we_o),
        .resp_rdata_o   (resp_rdata_o),
        .outs_cnt_o     (outs_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit we;
        int off;
        bit stale;
    } ent_t;

    ent_t      q[$];
    bit        pend, pend_fl, pend_we;
    bit [1:0]  pend_size;
    bit [31:0] pend_addr, pend_wdata;
    bit        e_rv, e_rwe;
    bit [31:0] e_rdata;
    int        n_checks = 0;
    int        n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mis(input bit [1:0] sz, input bit [31:0] a);
        case (sz)
            2'd1:    return a[0];
            2'd2:    return a[1:0] != 2'b00;
            2'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [3:0] strb_of(input bit we, input bit [1:0] sz, input bit [31:0] a);
        int n;
        if (!we) return 4'b0000;
        n = 1 << sz;
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic bit [31:0] rep_of(input bit [1:0] sz, input bit [31:0] wd);
        int        n;
        bit [31:0] r;
        n = 1 << sz;
        r = 0;
        for (int b = 0; b < 4; b++) begin
            r |= ((wd >> (8 * (b % n))) & 32'hFF) << (8 * b);
        end
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        pend  = 0;
        pend_fl = 0;
        e_rv  = 0;
        e_rwe = 0;
        e_rdata = 0;
    endtask

    // One clock: drive at the falling edge, compare, advance the model to the rising edge.
    task automatic cycle(input bit v, input bit we, input bit [1:0] sz, input bit [31:0] a,
                         input bit [31:0] wd, input bit fl, input bit aok, input bit dok,
                         input bit [31:0] rd);
        bit        e_ale, er, ew, hs, rdy, nrv;
        bit [1:0]  es;
        bit [31:0] ea, ewd;
        @(negedge clk);
        req_valid_i = v; req_we_i = we; req_size_i = sz; req_addr_i = a; req_wdata_i = wd;
        flush_i = fl; data_addr_ok_i = aok; data_data_ok_i = dok; data_rdata_i = rd;
        #1;
        e_ale = v & mis(sz, a);
        if (pend) begin
            er = 1; ew = pend_we; es = pend_size; ea = pend_addr; ewd = pend_wdata;
        end else begin
            er = v & !e_ale & !fl & (q.size() < MO);
            ew = we; es = sz; ea = a; ewd = wd;
        end
        check("ale", ale_o, e_ale);
        check("data_req", data_req_o, er);
        if (er) begin
            check("data_addr", data_addr_o, ea);
            check("data_wr", data_wr_o, ew);
            check("data_size", data_size_o, es);
            check("data_wstrb", data_wstrb_o, strb_of(ew, es, ea));
            check("data_wdata", data_wdata_o, rep_of(es, ewd));
        end
        hs  = er & aok;
        rdy = hs & !(pend & (pend_fl | fl));
        check("req_ready", req_ready_o, rdy);
        check("outs_cnt", outs_cnt_o, q.size());
        check("resp_valid", resp_valid_o, e_rv);
        if (e_rv) begin
            check("resp_we", resp_we_o, e_rwe);
            check("resp_rdata", resp_rdata_o, e_rdata);
        end
        nrv = 0;
        if (dok && q.size() > 0) begin
            ent_t h;
            h = q.pop_front();
            nrv = !(h.stale || fl);
            e_rwe = h.we;
            e_rdata = rd >> (8 * h.off);
        end
        e_rv = nrv;
        if (fl) begin
            foreach (q[i]) q[i].stale = 1;
        end
        if (hs) begin
            q.push_back('{we: ew, off: int'(ea % 4), stale: pend ? (pend_fl | fl) : fl});
            pend = 0;
        end else if (er && !pend) begin
            pend = 1; pend_fl = 0; pend_we = ew; pend_size = es; pend_addr = ea; pend_wdata = ewd;
        end else if (pend && fl) begin
            pend_fl = 1;
        end
        @(posedge clk);
    endtask

    task automatic idle(input bit dok, input bit [31:0] rd);
        cycle(0, 0, 0, 0, 0, 0, 0, dok, rd);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req_valid_i = 0; req_we_i = 0; req_size_i = 0; req_addr_i = 0; req_wdata_i = 0;
        flush_i = 0; data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 0;
        rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        req_valid_i = 0; req_we_i = 0; req_size_i = 0; req_addr_i = 0; req_wdata_i = 0;
        flush_i = 0; data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 0;
        model_reset();
        #1;
        check("rst_outs_cnt", outs_cnt_o, 0);
        check("rst_data_req", data_req_o, 0);
        check("rst_resp_valid", resp_valid_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        apply_reset();

        // Byte store into the top lane, address accepted at once.
        cycle(1, 1, 0, 32'h1003, 32'h0000_00AB, 0, 1, 0, 0);
        idle(1, 32'hDEAD_BEEF);
        idle(0, 0);
        // Misaligned word and illegal dword.
        cycle(1, 0, 2, 32'h2002, 0, 0, 1, 0, 0);
        cycle(1, 0, 3, 32'h2000, 0, 0, 1, 0, 0);
        // Address accepted only after three stalled cycles while EX moves on.
        cycle(1, 0, 2, 32'h3000, 0, 0, 0, 0, 0);
        cycle(1, 0, 2, 32'h4000, 0, 0, 0, 0, 0);
        cycle(1, 0, 2, 32'h4000, 0, 0, 0, 0, 0);
        cycle(1, 0, 2, 32'h4000, 0, 0, 1, 0, 0);
        idle(1, 32'h0BAD_F00D);
        // Fill both slots, third stalls until the first data returns.
        cycle(1, 0, 1, 32'h3002, 0, 0, 1, 0, 0);
        cycle(1, 0, 2, 32'h3004, 0, 0, 1, 0, 0);
        cycle(1, 0, 2, 32'h3008, 0, 0, 1, 0, 0);
        cycle(1, 0, 2, 32'h3008, 0, 0, 1, 1, 32'h1122_3344);
        cycle(1, 0, 2, 32'h3008, 0, 0, 1, 0, 0);
        idle(1, 32'h5555_6666);
        idle(1, 32'h7777_8888);
        idle(0, 0);
        // Flush with two outstanding: both returns are discarded.
        cycle(1, 0, 2, 32'h6000, 0, 0, 1, 0, 0);
        cycle(1, 1, 2, 32'h6004, 32'h1234_5678, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1, 32'hAAAA_AAAA);
        idle(1, 32'hBBBB_BBBB);
        idle(0, 0);
        // Reset while an address is being held, with one request outstanding.
        cycle(1, 0, 2, 32'h5000, 0, 0, 1, 0, 0);
        cycle(1, 0, 2, 32'h5004, 0, 0, 0, 0, 0);
        @(negedge clk);
        req_valid_i = 1; req_addr_i = 32'h5004; data_addr_ok_i = 0;
        #1 rst_n = 0;
        #1;
        check("rst_wait_data_req", data_req_o, 0);
        check("rst_wait_outs_cnt", outs_cnt_o, 0);
        check("rst_wait_req_ready", req_ready_o, 0);
        model_reset();
        req_valid_i = 0;
        @(negedge clk);
        rst_n = 1;
        idle(1, 32'h1357_9BDF);

        for (int i = 0; i < 3000; i++) begin
            bit [1:0]  sz;
            bit [31:0] a;
            int        r;
            r  = int'($urandom_range(7));
            sz = (r < 7) ? 2'(r % 3) : 2'd3;
            a  = $urandom;
            if ($urandom_range(3) != 0) a &= ~((32'd1 << sz) - 32'd1);
            cycle($urandom_range(9) < 7, 1'($urandom_range(1)), sz, a, $urandom,
                  $urandom_range(19) == 0, 1'($urandom_range(1)), $urandom_range(9) < 4,
                  $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
